// File: rtl/aud_pkg.sv
// ----------------------------------------------------------------------------
// aud_pkg
// Shared definitions for the audio I2S blocks: transmitter state encoding,
// LRCK slot polarity and the bit-counter width helper.
// ----------------------------------------------------------------------------
package aud_pkg;

    // Transmitter sequencing states
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAITL = 2'd1,
        S_LEFT  = 2'd2,
        S_RIGHT = 2'd3
    } aud_tx_state_e;

    // LRCK level that marks each channel slot
    localparam logic LRCK_LEFT  = 1'b0;
    localparam logic LRCK_RIGHT = 1'b1;

    // Width of a counter able to hold the values 0..data_w
    function automatic int bitcnt_w(input int data_w);
        return $clog2(data_w + 1);
    endfunction

endpackage

// File: rtl/aud_lrck_edge.sv
// ----------------------------------------------------------------------------
// aud_lrck_edge
// Registers the codec LRCK on the falling BCLK edge and flags slot starts.
//   i_bclk     : codec bit clock (falling-edge logic)
//   i_rst_n    : asynchronous active-low reset
//   i_daclrck  : codec LRCK, 0 = left slot, 1 = right slot
//   o_lf       : left slot begins on this edge (LRCK 1 -> 0)
//   o_rf       : right slot begins on this edge (LRCK 0 -> 1)
// ----------------------------------------------------------------------------
module aud_lrck_edge
    import aud_pkg::*;
(
    input  logic i_bclk,
    input  logic i_rst_n,
    input  logic i_daclrck,
    output logic o_lf,
    output logic o_rf
);

    logic r_lrck_q;

    // Previous LRCK level; reset to the left level so no slot event fires
    // while LRCK sits low after reset.
    always_ff @(negedge i_bclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_lrck_q <= LRCK_LEFT;
        end else begin
            r_lrck_q <= i_daclrck;
        end
    end

    assign o_lf = (r_lrck_q == LRCK_RIGHT) && (i_daclrck == LRCK_LEFT);
    assign o_rf = (r_lrck_q == LRCK_LEFT)  && (i_daclrck == LRCK_RIGHT);

endmodule

// File: rtl/aud_i2s_tx.sv
// ----------------------------------------------------------------------------
// aud_i2s_tx
// I2S DAC serializer with a one-deep frame buffer. Frames are shifted out
// MSB-first under codec-mastered BCLK/LRCK; an empty buffer at the start of
// a left slot plays zeros and bumps a saturating underflow counter.
//   i_bclk          : codec bit clock, all flops on its falling edge
//   i_rst_n         : asynchronous active-low reset
//   i_daclrck       : codec LRCK (0 left, 1 right)
//   i_en            : playback enable, sampled at left-slot starts
//   i_mono          : store i_left into both channels of the accepted frame
//   i_valid/o_ready : frame handshake, accept when both high
//   i_left/i_right  : two's complement samples, DATA_W bits
//   o_aud_dacdat    : serial DAC data
//   o_underflow     : one-cycle pulse when a left slot finds no frame
//   o_underflow_cnt : saturating underflow count
// ----------------------------------------------------------------------------
module aud_i2s_tx
    import aud_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              i_bclk,
    input  logic              i_rst_n,
    input  logic              i_daclrck,
    input  logic              i_en,
    input  logic              i_mono,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_left,
    input  logic [DATA_W-1:0] i_right,
    output logic              o_ready,
    output logic              o_aud_dacdat,
    output logic              o_underflow,
    output logic [CNT_W-1:0]  o_underflow_cnt
);

    localparam int              BCW       = bitcnt_w(DATA_W);
    localparam logic [BCW-1:0]  BITS_LOAD = BCW'(DATA_W - 1);

    logic                 w_lf;
    logic                 w_rf;
    logic                 w_accept;
    logic [DATA_W-1:0]    w_in_right;
    logic                 w_load_left;
    logic                 w_load_right;
    logic                 w_stop;
    logic                 w_to_waitl;

    logic                 r_ready;
    logic [DATA_W-1:0]    r_buf_l;
    logic [DATA_W-1:0]    r_buf_r;
    aud_tx_state_e        r_state;
    logic [DATA_W-1:0]    r_shift;
    logic [DATA_W-1:0]    r_right;
    logic [BCW-1:0]       r_bitcnt;
    logic                 r_dacdat;
    logic                 r_underflow;
    logic [CNT_W-1:0]     r_underflow_cnt;

    aud_lrck_edge u_lrck_edge (
        .i_bclk    (i_bclk),
        .i_rst_n   (i_rst_n),
        .i_daclrck (i_daclrck),
        .o_lf      (w_lf),
        .o_rf      (w_rf)
    );

    assign w_accept   = i_valid & r_ready;
    assign w_in_right = i_mono ? i_left : i_right;

    // Decode which slot action this edge performs in the current state
    always_comb begin
        w_load_left  = 1'b0;
        w_load_right = 1'b0;
        w_stop       = 1'b0;
        w_to_waitl   = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Only a right-slot start proves we are aligned to a frame
                if (w_rf) w_to_waitl = 1'b1;
                else      w_to_waitl = 1'b0;
            end
            S_WAITL: begin
                if (w_lf && i_en) w_load_left = 1'b1;
                else              w_load_left = 1'b0;
            end
            S_LEFT: begin
                if (w_rf) w_load_right = 1'b1;
                else      w_load_right = 1'b0;
            end
            S_RIGHT: begin
                if (w_lf) begin
                    if (i_en) w_load_left = 1'b1;
                    else      w_stop      = 1'b1;
                end else begin
                    w_load_left = 1'b0;
                end
            end
            default: begin
                w_to_waitl = 1'b0;
            end
        endcase
    end

    // One-deep frame buffer; r_ready doubles as the buffer-empty flag.
    // Consume and accept are mutually exclusive since accept needs empty.
    always_ff @(negedge i_bclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ready <= 1'b1;
            r_buf_l <= {DATA_W{1'b0}};
            r_buf_r <= {DATA_W{1'b0}};
        end else if (w_load_left && !r_ready) begin
            r_ready <= 1'b1;
        end else if (w_accept) begin
            r_ready <= 1'b0;
            r_buf_l <= i_left;
            r_buf_r <= w_in_right;
        end else begin
            r_ready <= r_ready;
        end
    end

    // Sequencer, shifter and underflow accounting
    always_ff @(negedge i_bclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state         <= S_IDLE;
            r_shift         <= {DATA_W{1'b0}};
            r_right         <= {DATA_W{1'b0}};
            r_bitcnt        <= {BCW{1'b0}};
            r_dacdat        <= 1'b0;
            r_underflow     <= 1'b0;
            r_underflow_cnt <= {CNT_W{1'b0}};
        end else begin
            r_underflow <= 1'b0;
            if (w_load_left) begin
                r_state  <= S_LEFT;
                r_bitcnt <= BITS_LOAD;
                if (!r_ready) begin
                    r_dacdat <= r_buf_l[DATA_W-1];
                    r_shift  <= {r_buf_l[DATA_W-2:0], 1'b0};
                    r_right  <= r_buf_r;
                end else begin
                    // Nothing buffered: play a silent frame
                    r_dacdat    <= 1'b0;
                    r_shift     <= {DATA_W{1'b0}};
                    r_right     <= {DATA_W{1'b0}};
                    r_underflow <= 1'b1;
                    if (~&r_underflow_cnt) r_underflow_cnt <= r_underflow_cnt + CNT_W'(1'b1);
                    else                   r_underflow_cnt <= r_underflow_cnt;
                end
            end else if (w_load_right) begin
                r_state  <= S_RIGHT;
                r_bitcnt <= BITS_LOAD;
                r_dacdat <= r_right[DATA_W-1];
                r_shift  <= {r_right[DATA_W-2:0], 1'b0};
            end else if (w_stop) begin
                // Enable dropped: right slot ends here, pin parks at 0
                r_state  <= S_WAITL;
                r_bitcnt <= {BCW{1'b0}};
                r_dacdat <= 1'b0;
                r_shift  <= {DATA_W{1'b0}};
            end else begin
                if (w_to_waitl) r_state <= S_WAITL;
                else            r_state <= r_state;
                if (r_bitcnt != {BCW{1'b0}}) begin
                    r_dacdat <= r_shift[DATA_W-1];
                    r_shift  <= {r_shift[DATA_W-2:0], 1'b0};
                    r_bitcnt <= r_bitcnt - BCW'(1'b1);
                end else begin
                    r_dacdat <= 1'b0;
                end
            end
        end
    end

    assign o_ready         = r_ready;
    assign o_aud_dacdat    = r_dacdat;
    assign o_underflow     = r_underflow;
    assign o_underflow_cnt = r_underflow_cnt;

endmodule
